// File: rtl/param_cache_controller.sv
// Cache controller between the MEM stage and main memory.
// Keeps only tag/valid/dirty/LRU state and drives the data-array strobes
// and the memory handshake. Direct-mapped or 2-way, write-through or write-back.
module param_cache_controller #(
  parameter int INDEX_W    = 5,
  parameter int TAG_W      = 3,
  parameter int ASSOC      = 1,
  parameter int WRITE_BACK = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic               stall,
  output logic               fill,
  output logic               update,
  output logic               way,
  output logic               hit,
  output logic               MsRead,
  output logic               MsWrite,
  output logic [TAG_W-1:0]   wb_tag,
  input  logic               MsReady
);
  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, RD_MISS, WR_MEM} state_t;
  state_t state;

  // Storage is always sized for two ways; way1 is never looked up or
  // written when ASSOC=1.
  logic [1:0][SETS-1:0]            valid, dirty;
  logic [1:0][SETS-1:0][TAG_W-1:0] tag_arr;
  logic [SETS-1:0]                 lru;      // way to replace next
  logic                            vway;     // victim way, held through the miss
  logic [TAG_W-1:0]                vtag;     // victim tag, held through the miss

  logic [1:0] match;
  logic       req, lk_hit, lk_way, vict, vict_wb;

  // per-way tag compare, ways beyond ASSOC never match
  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < ASSOC) begin : g_on
      assign match[w] = valid[w][index] && (tag_arr[w][index] == tag);
    end else begin : g_off
      assign match[w] = 1'b0;
    end
  end

  // request decode, hit way and victim choice (invalid way first, else LRU)
  always_comb begin
    req    = MemRead | MemWrite;
    lk_hit = |match;
    lk_way = ~match[0];
    vict   = 1'b0;
    if (ASSOC == 2) begin
      if (!valid[0][index])      vict = 1'b0;
      else if (!valid[1][index]) vict = 1'b1;
      else                       vict = lru[index];
    end
    vict_wb = (WRITE_BACK != 0) && valid[vict][index] && dirty[vict][index];
  end

  // output decode from state and lookup; everything held low during reset
  always_comb begin
    stall   = 1'b0;
    fill    = 1'b0;
    update  = 1'b0;
    way     = 1'b0;
    hit     = 1'b0;
    MsRead  = 1'b0;
    MsWrite = 1'b0;
    wb_tag  = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (lk_hit) begin
              hit = 1'b1;
              way = lk_way;
              if (!MemRead) begin
                update = 1'b1;
                stall  = (WRITE_BACK == 0);
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
        WB: begin
          MsWrite = 1'b1;
          stall   = 1'b1;
          wb_tag  = vtag;
        end
        RD_MISS: begin
          MsRead = 1'b1;
          stall  = 1'b1;
          if (MsReady) begin
            fill = 1'b1;
            way  = vway;
          end
        end
        WR_MEM: begin
          MsWrite = 1'b1;
          stall   = ~MsReady;
        end
        default: ;
      endcase
    end
  end

  // state transitions and tag/valid/dirty/LRU maintenance
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      lru   <= '0;
      vway  <= 1'b0;
      vtag  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (lk_hit) begin
              lru[index] <= ~lk_way;
              if (!MemRead) begin
                if (WRITE_BACK != 0) dirty[lk_way][index] <= 1'b1;
                else                 state <= WR_MEM;
              end
            end else if (MemRead || (WRITE_BACK != 0)) begin
              // write-allocate misses take the read-miss path, then retry
              vway  <= vict;
              vtag  <= tag_arr[vict][index];
              state <= vict_wb ? WB : RD_MISS;
            end else begin
              state <= WR_MEM;
            end
          end
        end
        WB: begin
          if (MsReady) begin
            dirty[vway][index] <= 1'b0;
            state              <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (MsReady) begin
            tag_arr[vway][index] <= tag;
            valid[vway][index]   <= 1'b1;
            dirty[vway][index]   <= 1'b0;
            lru[index]           <= ~vway;
            state                <= IDLE;
          end
        end
        WR_MEM: begin
          if (MsReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_cache_controller.sv
// Bench for param_cache_controller: four instances covering every
// ASSOC/WRITE_BACK combination, each driven by directed then random
// transactions and checked every cycle against a transaction-level model.
module tb_param_cache_controller;
  localparam int IW   = 5;
  localparam int TW   = 3;
  localparam int SETS = 1 << IW;

  typedef struct packed {
    logic          stall, fill, update, way, hit, msr, msw;
    logic [TW-1:0] wbt;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit done [4];
  int waited      = 0;

  function automatic out_t mk(bit st, bit fl, bit up, bit wy, bit ht, bit mr, bit mw, int wt);
    out_t o;
    o.stall = st; o.fill = fl; o.update = up; o.way = wy;
    o.hit = ht; o.msr = mr; o.msw = mw; o.wbt = wt[TW-1:0];
    return o;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int A   = (c % 2) + 1;
    localparam int WBP = c / 2;

    logic          reset, rd, wr, rdy;
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    logic          stall, fill, update, way, hit, msr, msw;
    logic [TW-1:0] wbt;

    param_cache_controller #(.INDEX_W(IW), .TAG_W(TW), .ASSOC(A), .WRITE_BACK(WBP)) dut (
      .clk(clk), .reset(reset), .MemRead(rd), .MemWrite(wr), .index(idx), .tag(tg),
      .stall(stall), .fill(fill), .update(update), .way(way), .hit(hit),
      .MsRead(msr), .MsWrite(msw), .wb_tag(wbt), .MsReady(rdy)
    );

    // abstract cache contents
    bit          mv [2][SETS];
    bit          md [2][SETS];
    int          mt [2][SETS];
    bit          ml [SETS];

    out_t exp, got;
    bit   chk = 0;
    // per-transaction observations used by the literal checks
    bit   first, first_hit, last_hit, last_fill_way, seen_upd, seen_msw;
    int   seen_wbt;

    // cycle compare against the model's expectation
    always @(negedge clk) begin
      if (chk) begin
        got = {stall, fill, update, way, hit, msr, msw, wbt};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL cfg%0d cycle t=%0t got(st,fl,up,wy,ht,mr,mw,wbt)=%b required=%b",
                   c, $time, got, exp);
        end
        if (first) begin first_hit = hit; first = 0; end
        last_hit = hit;
        if (fill) last_fill_way = way;
        if (update) seen_upd = 1;
        if (msw) seen_msw = 1;
        if (msw && wbt != 0) seen_wbt = int'(wbt);
      end
    end

    task automatic lit(string nm, int g, int w);
      vectors++;
      if (g != w) begin
        miscompares++;
        $display("FAIL cfg%0d %s got=%0d required=%0d", c, nm, g, w);
      end
    endtask

    task automatic cyc(out_t e, bit r);
      rdy = r;
      exp = e;
      chk = 1;
      @(posedge clk);
      #1;
    endtask

    function automatic int find(int i, int t);
      for (int w = 0; w < A; w++) if (mv[w][i] && mt[w][i] == t) return w;
      return -1;
    endfunction

    function automatic int victim(int i);
      for (int w = 0; w < A; w++) if (!mv[w][i]) return w;
      return (A == 2) ? int'(ml[i]) : 0;
    endfunction

    task automatic mem_write();
      int lat = $urandom_range(1, 3);
      for (int k = 1; k <= lat; k++) cyc(mk(k != lat, 0, 0, 0, 0, 0, 1, 0), k == lat);
    endtask

    task automatic txn(bit r, bit w, int i, int t);
      int  hw, v, lat;
      bit  fin = 0;
      rd = r; wr = w; idx = i[IW-1:0]; tg = t[TW-1:0];
      first = 1; seen_upd = 0; seen_msw = 0; seen_wbt = 0;
      while (!fin) begin
        hw = find(i, t);
        if (!(r | w)) begin
          cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
          fin = 1;
        end else if (hw >= 0) begin
          ml[i] = (hw == 0);
          if (r) cyc(mk(0, 0, 0, hw == 1, 1, 0, 0, 0), 1'($urandom_range(0, 1)));
          else if (WBP != 0) begin
            md[hw][i] = 1;
            cyc(mk(0, 0, 1, hw == 1, 1, 0, 0, 0), 1'($urandom_range(0, 1)));
          end else begin
            cyc(mk(1, 0, 1, hw == 1, 1, 0, 0, 0), 1'($urandom_range(0, 1)));
            mem_write();
          end
          fin = 1;
        end else if (w && !r && WBP == 0) begin
          cyc(mk(1, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
          mem_write();
          fin = 1;
        end else begin
          v = victim(i);
          cyc(mk(1, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
          if (WBP != 0 && mv[v][i] && md[v][i]) begin
            lat = $urandom_range(1, 3);
            for (int k = 1; k <= lat; k++) cyc(mk(1, 0, 0, 0, 0, 0, 1, mt[v][i]), k == lat);
            md[v][i] = 0;
          end
          lat = $urandom_range(1, 3);
          for (int k = 1; k <= lat; k++)
            cyc(mk(1, k == lat, 0, (k == lat) && (v == 1), 0, 1, 0, 0), k == lat);
          mv[v][i] = 1; mt[v][i] = t; md[v][i] = 0; ml[i] = (v == 0);
        end
      end
      rd = 0; wr = 0;
    endtask

    task automatic do_reset();
      reset = 1;
      for (int k = 0; k < 2; k++) begin
        rd  = 1'($urandom_range(0, 1));
        wr  = 1'($urandom_range(0, 1));
        idx = IW'($urandom_range(0, SETS - 1));
        tg  = TW'($urandom_range(0, 7));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
      end
      for (int s = 0; s < SETS; s++) begin
        mv[0][s] = 0; mv[1][s] = 0; md[0][s] = 0; md[1][s] = 0; ml[s] = 0;
      end
      reset = 0; rd = 0; wr = 0;
    endtask

    initial begin
      int op;
      reset = 1; rd = 0; wr = 0; rdy = 0; idx = '0; tg = '0;
      @(posedge clk);
      #1;
      do_reset();
      txn(0, 0, 0, 0);

      // cold read miss, then the retried hit
      txn(1, 0, 5, 2);
      lit("cold_first_hit", first_hit, 0);
      lit("cold_fill_way", last_fill_way, 0);
      lit("cold_last_hit", last_hit, 1);
      // write hit: update always, memory write only when write-through
      txn(0, 1, 5, 2);
      lit("wr_hit_update", seen_upd, 1);
      lit("wr_hit_mswrite", seen_msw, WBP == 0);
      // write miss: allocate only when write-back (victim dirty when direct-mapped)
      txn(0, 1, 5, 5);
      lit("wr_miss_update", seen_upd, WBP);
      lit("wr_miss_mswrite", seen_msw, (WBP == 0) || (A == 1));

      // LRU sequence on set 3
      txn(1, 0, 3, 1);
      txn(1, 0, 3, 2);
      txn(1, 0, 3, 1);
      lit("lru_rehit", first_hit, A == 2);
      txn(1, 0, 3, 4);
      lit("lru_evict_way", last_fill_way, A == 2);

      // read and write together on a hit act as a pure read
      txn(1, 0, 4, 6);
      txn(1, 1, 4, 6);
      lit("rdwr_first_hit", first_hit, 1);
      lit("rdwr_update", seen_upd, 0);
      lit("rdwr_mswrite", seen_msw, 0);

      // dirty victim writeback on set 7
      txn(0, 1, 7, 1);
      txn(1, 0, 7, 3);
      lit("victim_wb_tag", seen_wbt, (WBP != 0 && A == 1) ? 1 : 0);

      // reset in the middle of a read miss abandons it and clears the lines
      txn(1, 0, 9, 1);
      rd = 1; wr = 0; idx = 9; tg = 2;
      cyc(mk(1, 0, 0, 0, 0, 0, 0, 0), 0);
      cyc(mk(1, 0, 0, 0, 0, 1, 0, 0), 0);
      do_reset();
      txn(0, 0, 0, 0);
      txn(1, 0, 9, 1);
      lit("miss_after_reset", first_hit, 0);

      // random traffic over a small footprint so hits and evictions are common
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(0, 60) == 0) do_reset();
        else begin
          op = $urandom_range(0, 5);
          txn(op == 1 || op == 2 || op == 5, op == 3 || op == 4 || op == 5,
              $urandom_range(0, 3), $urandom_range(0, 3));
        end
      end
      chk = 0;
      done[c] = 1;
    end
  end

  initial begin
    while (!(done[0] && done[1] && done[2] && done[3]) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (!(done[0] && done[1] && done[2] && done[3])) begin
      miscompares++;
      $display("FAIL timeout done=%0d%0d%0d%0d required=1111", done[0], done[1], done[2], done[3]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/param_cache_controller.md
Name: param_cache_controller

Overview:
- Parametrised successor to the direct-mapped data-cache controller.
- Generalises the index and tag widths and adds an optional 2-way set-associative mode with LRU replacement.
- Adds a selectable write-back/write-allocate policy that uses dirty bits and a victim-writeback handshake.
- Sits between the pipeline MEM stage and main memory: it drives the cache-array control strobes (fill, update, way) and the memory handshake (MsRead/MsWrite/MsReady). It holds only tag/valid/dirty/LRU state; data arrays live outside.

Parameters:
- INDEX_W, 5, set-index width; the controller has 2^INDEX_W sets.
- TAG_W, 3, tag width.
- ASSOC, 1, associativity; legal values are 1 (direct-mapped) and 2 (2-way).
- WRITE_BACK, 0, write policy:
  - 0: write-through, no-write-allocate.
  - 1: write-back, write-allocate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from MEM stage.
- MemWrite  in  1  store request from MEM stage.
- index  in  INDEX_W  set index of the request.
- tag  in  TAG_W  tag of the request.
- stall  out  1  holds the pipeline.
- fill  out  1  write the returned memory block into the data array at (index, way).
- update  out  1  write the store data into the data array at (index, way).
- way  out  1  selected way for hit, fill or update; constant 0 when ASSOC=1.
- hit  out  1  request hits in the current cycle (IDLE state only).
- MsRead  out  1  main-memory block read request.
- MsWrite  out  1  main-memory write request (write-through word, or victim block).
- wb_tag  out  TAG_W  victim tag during writeback; 0 otherwise.
- MsReady  in  1  memory completes the current MsRead/MsWrite.

Behaviour:
- Reset:
  - state <= IDLE.
  - All valid, dirty and LRU bits cleared.
  - While reset is high, all outputs are forced to 0.
  - Reset mid-miss abandons the transaction with no fill and no update.
- Outputs are combinational from state, the request inputs and the array lookup.
- Lookup: hit = MemRead|MemWrite, and in some way w: valid[w][index] && tag_arr[w][index]==tag; way = w.
- MemRead has priority if both requests are high; MemWrite is then ignored.
- Victim selection:
  - First invalid way, way0 before way1.
  - Otherwise the way given by lru[index].
  - ASSOC=1 always selects way0.
- LRU: on every hit or fill, lru[index] <= the way not used.
- States: IDLE, WB, RD_MISS, WR_MEM.
- IDLE:
  - Read hit: stall=0, no other strobes; zero-cycle latency.
  - Read miss: stall=1. Next state is WB if WRITE_BACK && victim valid && victim dirty, else RD_MISS.
  - Write hit, WRITE_BACK=0: update=1 this cycle, stall=1, next state WR_MEM.
  - Write hit, WRITE_BACK=1: update=1, dirty set, stall=0, stay in IDLE.
  - Write miss, WRITE_BACK=0: no update, stall=1, next state WR_MEM (no allocate).
  - Write miss, WRITE_BACK=1: handled as a read miss (WB/RD_MISS), then retried in IDLE as a write hit.
  - No request: all outputs 0.
- WB:
  - MsWrite=1, stall=1, wb_tag=victim tag.
  - On MsReady: clear dirty[victim], next state RD_MISS.
- RD_MISS:
  - MsRead=1, stall=1.
  - On MsReady (same cycle): fill=1, way=victim, tag_arr<=tag, valid<=1, dirty<=0, LRU updated; next state IDLE.
  - The request must still be present; the next IDLE cycle re-evaluates it as a hit.
- WR_MEM:
  - MsWrite=1, stall=~MsReady.
  - On MsReady: next state IDLE; the pipeline advances that same cycle, so the store is not reissued.
- The victim way and tag are latched on entry to WB/RD_MISS and held until return to IDLE.
- MsReady is ignored in IDLE.
- MsRead and MsWrite are never high together.
- fill and update are never high together.
- index and tag must be held stable by the pipeline while stall=1; the controller does not re-latch them.

Test Plan:
- Cold read miss (ASSOC=1, WRITE_BACK=0), index=5, tag=2, MemRead=1:
  - Cycle 0: stall=1. From cycle 1: MsRead=1 until MsReady.
  - MsReady cycle: fill=1, way=0.
  - Next cycle: hit=1, stall=0.
- Write-through, write miss index=5 tag=5: no update, MsWrite=1 until MsReady, stall drops in the MsReady cycle. A following write with index=5 tag=2 produces update=1 in IDLE, then MsWrite.
- 2-way LRU (ASSOC=2):
  - Read-miss fills: index=3 tag=1 fills way0; index=3 tag=2 fills way1.
  - Read tag=1 hits way0.
  - Miss on tag=4 evicts way1 (fill with way=1).
- Write-back (WRITE_BACK=1, ASSOC=1):
  - Write miss index=7 tag=1: RD_MISS fill, then update=1 with stall=0, leaving dirty set.
  - Read index=7 tag=3: MsWrite with wb_tag=1 first, then MsRead, then fill.
- Reset asserted during RD_MISS: MsRead and stall drop the next cycle, no fill occurs, and a previously valid line now misses.
- Simultaneous MemRead=1 and MemWrite=1 on a hit: no update and no MsWrite; treated purely as a read.
